// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the I-cache / D-cache memory-port arbiter:
// one-hot FSM state codes, grant owner encoding and the round-robin pick.
package cache_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'b001,
    ARB_IC   = 3'b010,
    ARB_DC   = 3'b100
  } arb_state_e;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } gnt_e;

  // i_req[0] = I-cache, i_req[1] = D-cache; only meaningful when any bit is set.
  function automatic gnt_e rr_pick(input logic [1:0] i_req, input gnt_e i_last);
    gnt_e w_pick;
    if (i_req == 2'b11) begin
      if (i_last == GNT_DC) w_pick = GNT_IC;
      else                  w_pick = GNT_DC;
    end else if (i_req[0]) begin
      w_pick = GNT_IC;
    end else begin
      w_pick = GNT_DC;
    end
    return w_pick;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Round-robin share of one memory port between I-cache refill and D-cache miss/writeback,
// one outstanding transaction, with a BUSY-cycle watchdog that aborts a stuck bus.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ic_req,
  input  logic [63:0] i_ic_addr,
  output logic [31:0] o_ic_rdata,
  output logic        o_ic_ok,
  input  logic        i_dc_req,
  input  logic        i_dc_we,
  input  logic [63:0] i_dc_addr,
  input  logic [63:0] i_dc_wdata,
  input  logic [7:0]  i_dc_wmask,
  output logic [63:0] o_dc_rdata,
  output logic        o_dc_ok,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [63:0] o_mem_addr,
  output logic [63:0] o_mem_wdata,
  output logic [7:0]  o_mem_wmask,
  input  logic [63:0] i_mem_rdata,
  input  logic        i_mem_ok,
  output logic        o_bus_err
);

  arb_state_e       r_state, w_state_nxt;
  gnt_e             r_last_gnt;
  logic [CNT_W-1:0] r_wdog;
  logic [63:0]      r_addr, r_wdata;
  logic [7:0]       r_wmask;
  logic             r_we;
  logic             w_grant_ic, w_grant_dc, w_wdog_exp;
  logic             w_ic_ok, w_dc_ok, w_bus_err;

  if (TIMEOUT > 0) begin : g_wdog
    assign w_wdog_exp = (r_wdog == CNT_W'(TIMEOUT - 1));
  end else begin : g_no_wdog
    assign w_wdog_exp = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ARB_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_ic  = 1'b0;
    w_grant_dc  = 1'b0;
    w_ic_ok     = 1'b0;
    w_dc_ok     = 1'b0;
    w_bus_err   = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (i_ic_req || i_dc_req) begin
          if (rr_pick({i_dc_req, i_ic_req}, r_last_gnt) == GNT_IC) begin
            w_grant_ic  = 1'b1;
            w_state_nxt = ARB_IC;
          end else begin
            w_grant_dc  = 1'b1;
            w_state_nxt = ARB_DC;
          end
        end
      end
      ARB_IC: begin
        if (i_mem_ok || w_wdog_exp) begin
          w_ic_ok     = 1'b1;
          w_bus_err   = !i_mem_ok;
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_DC: begin
        if (i_mem_ok || w_wdog_exp) begin
          w_dc_ok     = 1'b1;
          w_bus_err   = !i_mem_ok;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Request attributes are frozen at grant so the bus sees stable values until completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_gnt <= GNT_DC;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_we       <= 1'b0;
    end else if (w_grant_ic) begin
      r_last_gnt <= GNT_IC;
      r_addr     <= i_ic_addr;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_we       <= 1'b0;
    end else if (w_grant_dc) begin
      r_last_gnt <= GNT_DC;
      r_addr     <= i_dc_addr;
      r_wdata    <= i_dc_wdata;
      r_wmask    <= i_dc_wmask;
      r_we       <= i_dc_we;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_wdog <= '0;
    else if (w_state_nxt == ARB_IDLE)           r_wdog <= '0;
    else if (r_state != ARB_IDLE && !i_mem_ok)  r_wdog <= r_wdog + 1'b1;
  end

  assign o_mem_req   = (r_state != ARB_IDLE);
  assign o_mem_we    = o_mem_req & r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_wmask = r_wmask;
  assign o_ic_ok     = w_ic_ok;
  assign o_dc_ok     = w_dc_ok;
  assign o_bus_err   = w_bus_err;

  // Read data is only forwarded on a genuine completion; an abort returns zero.
  assign o_ic_rdata = (w_ic_ok && i_mem_ok) ? (r_addr[2] ? i_mem_rdata[63:32] : i_mem_rdata[31:0]) : 32'h0;
  assign o_dc_rdata = (w_dc_ok && i_mem_ok) ? i_mem_rdata : 64'h0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reset, IC fetch, DC write, round-robin,
// watchdog abort (TIMEOUT=4) and a request queued behind a busy transaction.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ic_req = 1'b0;
  logic [63:0] ic_addr = '0;
  logic [31:0] ic_rdata;
  logic        ic_ok;
  logic        dc_req = 1'b0;
  logic        dc_we = 1'b0;
  logic [63:0] dc_addr = '0;
  logic [63:0] dc_wdata = '0;
  logic [7:0]  dc_wmask = '0;
  logic [63:0] dc_rdata;
  logic        dc_ok;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_rdata = '0;
  logic        mem_ok = 1'b0;
  logic        bus_err;

  int n_pass  = 0;
  int n_total = 0;

  cache_mem_arbiter #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .i_ic_req(ic_req), .i_ic_addr(ic_addr), .o_ic_rdata(ic_rdata), .o_ic_ok(ic_ok),
    .i_dc_req(dc_req), .i_dc_we(dc_we), .i_dc_addr(dc_addr), .i_dc_wdata(dc_wdata),
    .i_dc_wmask(dc_wmask), .o_dc_rdata(dc_rdata), .o_dc_ok(dc_ok),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_wmask(mem_wmask), .i_mem_rdata(mem_rdata), .i_mem_ok(mem_ok), .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_total++; if (mem_req !== 1'b0 || ic_ok !== 1'b0 || dc_ok !== 1'b0 || bus_err !== 1'b0)
      $display("FAIL reset_outputs: req/icok/dcok/err=%b%b%b%b want 0000", mem_req, ic_ok, dc_ok, bus_err);
    else n_pass++;
    ic_addr = 64'h8000_0008;
    ic_req  = 1'b1;
    cyc();
    n_total++; if (mem_req !== 1'b1) $display("FAIL reset_busy_req: got %b want 1", mem_req); else n_pass++;
    mem_ok = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_total++; if (mem_req !== 1'b0) $display("FAIL reset_async_req: got %b want 0", mem_req); else n_pass++;
    n_total++; if (ic_ok !== 1'b0) $display("FAIL reset_no_ok: got %b want 0", ic_ok); else n_pass++;
    cyc();
    rst    = 1'b1;
    ic_req = 1'b0;
    cyc();
    #1;
    n_total++; if (mem_req !== 1'b0 || ic_ok !== 1'b0)
      $display("FAIL reset_idle_after: req/ok=%b%b want 00 (mem_ok in IDLE)", mem_req, ic_ok);
    else n_pass++;
    mem_ok = 1'b0;
  endtask

  task automatic test_ic_fetch();
    int ok_count = 0;
    ic_addr = 64'h8000_0004;
    ic_req  = 1'b1;
    cyc();
    n_total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h8000_0004 || mem_wmask !== 8'h0)
      $display("FAIL ic_bus: req=%b we=%b addr=%h mask=%h want 1 0 8000_0004 00", mem_req, mem_we, mem_addr, mem_wmask);
    else n_pass++;
    ok_count += ic_ok;
    cyc();
    ok_count += ic_ok;
    cyc();
    mem_rdata = 64'h1111_2222_3333_4444;
    mem_ok    = 1'b1;
    #1;
    ok_count += ic_ok;
    n_total++; if (ic_rdata !== 32'h1111_2222) $display("FAIL ic_rdata: got %h want 11112222", ic_rdata); else n_pass++;
    n_total++; if (dc_ok !== 1'b0 || dc_rdata !== 64'h0 || bus_err !== 1'b0)
      $display("FAIL ic_nonowner: dcok=%b dcrdata=%h err=%b want 0 0 0", dc_ok, dc_rdata, bus_err);
    else n_pass++;
    cyc();
    mem_ok = 1'b0;
    ic_req = 1'b0;
    #1;
    ok_count += ic_ok;
    n_total++; if (ok_count != 1) $display("FAIL ic_ok_pulses: got %0d want 1", ok_count); else n_pass++;
    n_total++; if (mem_req !== 1'b0) $display("FAIL ic_idle: mem_req=%b want 0", mem_req); else n_pass++;
  endtask

  task automatic test_dc_write();
    dc_req   = 1'b1;
    dc_we    = 1'b1;
    dc_addr  = 64'h8000_1000;
    dc_wdata = 64'hDEAD_BEEF_0123_4567;
    dc_wmask = 8'h0F;
    cyc();
    n_total++; if (mem_we !== 1'b1 || mem_wmask !== 8'h0F || mem_addr !== 64'h8000_1000 || mem_wdata !== 64'hDEAD_BEEF_0123_4567)
      $display("FAIL dc_bus: we=%b mask=%h addr=%h wdata=%h", mem_we, mem_wmask, mem_addr, mem_wdata);
    else n_pass++;
    dc_addr  = 64'h1234_5678;
    dc_wmask = 8'hFF;
    dc_wdata = 64'h0;
    cyc();
    n_total++; if (mem_addr !== 64'h8000_1000 || mem_wmask !== 8'h0F || mem_wdata !== 64'hDEAD_BEEF_0123_4567 || mem_we !== 1'b1)
      $display("FAIL dc_stable: addr=%h mask=%h wdata=%h we=%b", mem_addr, mem_wmask, mem_wdata, mem_we);
    else n_pass++;
    n_total++; if (dc_ok !== 1'b0) $display("FAIL dc_early_ok: got %b want 0", dc_ok); else n_pass++;
    mem_ok = 1'b1;
    #1;
    n_total++; if (dc_ok !== 1'b1 || ic_ok !== 1'b0 || ic_rdata !== 32'h0)
      $display("FAIL dc_ok: dcok=%b icok=%b icrdata=%h want 1 0 0", dc_ok, ic_ok, ic_rdata);
    else n_pass++;
    cyc();
    mem_ok = 1'b0;
    dc_req = 1'b0;
    dc_we  = 1'b0;
    #1;
    n_total++; if (dc_ok !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL dc_after: dcok=%b req=%b we=%b want 000", dc_ok, mem_req, mem_we);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic exp_ic;
    apply_reset();
    ic_addr  = 64'h0000_0000_0000_1100;
    dc_addr  = 64'h0000_0000_0000_2200;
    dc_we    = 1'b0;
    dc_wmask = 8'h0;
    ic_req   = 1'b1;
    dc_req   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_ic = ((k % 2) == 0);
      cyc();
      n_total++; if (mem_req !== 1'b1 || mem_addr !== (exp_ic ? 64'h1100 : 64'h2200))
        $display("FAIL rr_grant%0d: req=%b addr=%h want ic=%b", k, mem_req, mem_addr, exp_ic);
      else n_pass++;
      mem_ok = 1'b1;
      #1;
      n_total++; if (ic_ok !== exp_ic || dc_ok !== !exp_ic)
        $display("FAIL rr_ok%0d: icok=%b dcok=%b want ic=%b", k, ic_ok, dc_ok, exp_ic);
      else n_pass++;
      cyc();
      mem_ok = 1'b0;
      if (k == 3) begin
        ic_req = 1'b0;
        dc_req = 1'b0;
      end
      #1;
      n_total++; if (mem_req !== 1'b0) $display("FAIL rr_idle%0d: mem_req=%b want 0", k, mem_req); else n_pass++;
    end
  endtask

  task automatic test_watchdog();
    dc_req    = 1'b1;
    dc_we     = 1'b0;
    dc_addr   = 64'h8000_2000;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      #1;
      if (c < 4) begin
        n_total++; if (bus_err !== 1'b0 || dc_ok !== 1'b0 || mem_req !== 1'b1)
          $display("FAIL wd_cycle%0d: err=%b dcok=%b req=%b want 0 0 1", c, bus_err, dc_ok, mem_req);
        else n_pass++;
      end else begin
        n_total++; if (bus_err !== 1'b1 || dc_ok !== 1'b1 || dc_rdata !== 64'h0 || ic_ok !== 1'b0)
          $display("FAIL wd_abort: err=%b dcok=%b rdata=%h icok=%b want 1 1 0 0", bus_err, dc_ok, dc_rdata, ic_ok);
        else n_pass++;
      end
    end
    cyc();
    dc_req = 1'b0;
    #1;
    n_total++; if (mem_req !== 1'b0 || bus_err !== 1'b0 || dc_ok !== 1'b0)
      $display("FAIL wd_idle: req=%b err=%b dcok=%b want 000", mem_req, bus_err, dc_ok);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 64'h8000_3000;
    cyc();
    ic_addr = 64'h8000_0040;
    ic_req  = 1'b1;
    cyc();
    mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    mem_ok    = 1'b1;
    #1;
    n_total++; if (dc_ok !== 1'b1 || dc_rdata !== 64'hAAAA_BBBB_CCCC_DDDD || ic_ok !== 1'b0)
      $display("FAIL b2b_dc: dcok=%b rdata=%h icok=%b", dc_ok, dc_rdata, ic_ok);
    else n_pass++;
    cyc();
    mem_ok = 1'b0;
    dc_req = 1'b0;
    #1;
    n_total++; if (mem_req !== 1'b0) $display("FAIL b2b_gap: mem_req=%b want 0", mem_req); else n_pass++;
    cyc();
    n_total++; if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0040 || mem_we !== 1'b0 || mem_wmask !== 8'h0)
      $display("FAIL b2b_ic_grant: req=%b addr=%h we=%b mask=%h", mem_req, mem_addr, mem_we, mem_wmask);
    else n_pass++;
    mem_rdata = 64'h5555_6666_7777_8888;
    mem_ok    = 1'b1;
    #1;
    n_total++; if (ic_ok !== 1'b1 || ic_rdata !== 32'h7777_8888)
      $display("FAIL b2b_ic_rdata: ok=%b rdata=%h want 1 77778888", ic_ok, ic_rdata);
    else n_pass++;
    cyc();
    ic_req = 1'b0;
    #1;
    n_total++; if (ic_ok !== 1'b0 || dc_ok !== 1'b0)
      $display("FAIL idle_mem_ok: icok=%b dcok=%b want 00", ic_ok, dc_ok);
    else n_pass++;
    mem_ok = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ic_fetch();
    test_dc_write();
    test_round_robin();
    test_watchdog();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
